// File: rtl/cpu7_ecl_except_pkg.sv
// cpu7_ecl_except_pkg: exception codes and arbiter FSM states for the _e stage.
package cpu7_ecl_except_pkg;

    localparam logic [5:0] LEXC_INT  = 6'h00;
    localparam logic [5:0] LEXC_ADEF = 6'h08;
    localparam logic [5:0] LEXC_ALE  = 6'h09;
    localparam logic [5:0] LEXC_SYS  = 6'h0B;
    localparam logic [5:0] LEXC_BRK  = 6'h0C;
    localparam logic [5:0] LEXC_INE  = 6'h0D;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_KILL = 1'b1
    } ecl_state_e;

endpackage

// File: rtl/cpu7_ecl_except_intr_sync.sv
// cpu7_ecl_except_intr_sync: SYNC_STAGES-deep flop chain bringing ext_intr into clk.
module cpu7_ecl_except_intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cpu7_ecl_except.sv
// cpu7_ecl_except: _e-stage exception/interrupt arbiter; picks a winner, drives CSR
// update and IFU redirect, then squashes wrong-path _e instructions for FLUSH_CYC cycles.
module cpu7_ecl_except
    import cpu7_ecl_except_pkg::*;
#(
    parameter int FLUSH_CYC   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifu_exu_valid_e,
    input  logic        ecl_stall_e,
    input  logic [31:0] ifu_exu_pc_e,
    input  logic        ifu_exu_adef_e,
    input  logic        ecl_illinst_e,
    input  logic        ecl_syscall_e,
    input  logic        ecl_break_e,
    input  logic        ecl_ale_e,
    input  logic [31:0] ecl_ldst_addr_e,
    input  logic        ecl_ertn_e,
    input  logic        csr_ecl_crmd_ie,
    input  logic        csr_ecl_timer_intr,
    input  logic        ext_intr,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        exu_ifu_except,
    output logic [5:0]  ecl_csr_exccode_e,
    output logic [31:0] ecl_csr_badv_e,
    output logic        ecl_csr_ertn_e,
    output logic        exu_ifu_redirect,
    output logic [31:0] exu_ifu_redirect_pc,
    output logic        ecl_kill_e,
    output logic        ext_intr_sync
);

    localparam int CW = FLUSH_CYC > 1 ? $clog2(FLUSH_CYC) : 1;

    ecl_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          go, int_pend, fault, sel_adef, sel_ale;
    logic [5:0]    code;

    cpu7_ecl_except_intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_intr_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ext_intr),
        .q_o   (ext_intr_sync)
    );

    // Gating on reset keeps every output at 0 while reset is held.
    assign go       = ~reset & ifu_exu_valid_e & ~ecl_stall_e & (state_q == ST_IDLE);
    assign int_pend = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_sync);
    assign fault    = ifu_exu_adef_e | ecl_illinst_e | ecl_syscall_e | ecl_break_e | ecl_ale_e;
    assign sel_adef = ~int_pend & ifu_exu_adef_e;
    assign sel_ale  = ~int_pend & ~ifu_exu_adef_e & ~ecl_illinst_e & ~ecl_syscall_e
                    & ~ecl_break_e & ecl_ale_e;

    assign code = int_pend       ? LEXC_INT  :
                  ifu_exu_adef_e ? LEXC_ADEF :
                  ecl_illinst_e  ? LEXC_INE  :
                  ecl_syscall_e  ? LEXC_SYS  :
                  ecl_break_e    ? LEXC_BRK  :
                  ecl_ale_e      ? LEXC_ALE  : LEXC_INT;

    assign exu_ifu_except      = go & (int_pend | fault);
    assign ecl_csr_exccode_e   = exu_ifu_except ? code : 6'h00;
    assign ecl_csr_badv_e      = ~exu_ifu_except ? 32'h0 :
                                 sel_adef ? ifu_exu_pc_e :
                                 sel_ale  ? ecl_ldst_addr_e : 32'h0;
    assign ecl_csr_ertn_e      = go & ecl_ertn_e & ~exu_ifu_except;
    assign exu_ifu_redirect    = exu_ifu_except | ecl_csr_ertn_e;
    assign exu_ifu_redirect_pc = exu_ifu_except ? csr_eentry :
                                 ecl_csr_ertn_e ? csr_era : 32'h0;
    assign ecl_kill_e          = ~reset & (state_q == ST_KILL ? ifu_exu_valid_e : exu_ifu_except);

    // KILL lasts FLUSH_CYC cycles; the counter runs through stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (exu_ifu_redirect) begin
                state_q <= ST_KILL;
                cnt_q   <= CW'(FLUSH_CYC - 1);
            end
        end else begin
            cnt_q   <= cnt_q == '0 ? '0 : cnt_q - CW'(1);
            state_q <= cnt_q == '0 ? ST_IDLE : ST_KILL;
        end
    end

endmodule

// File: tb/tb_cpu7_ecl_except.sv
// tb_cpu7_ecl_except: directed vectors for the _e-stage exception arbiter.
module tb_cpu7_ecl_except;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_e, stall_e, adef, ill, sys, brk, ale, ertn_e, ie, timer, ext;
    logic [31:0] pc_e, ldst, eentry, era;
    logic        except_o, ertn_o, redir_o, kill_o, sync_o;
    logic [5:0]  code_o;
    logic [31:0] badv_o, rpc_o;
    int          total = 0;
    int          bad = 0;

    cpu7_ecl_except dut (
        .clk                 (clk),
        .reset               (reset),
        .ifu_exu_valid_e     (valid_e),
        .ecl_stall_e         (stall_e),
        .ifu_exu_pc_e        (pc_e),
        .ifu_exu_adef_e      (adef),
        .ecl_illinst_e       (ill),
        .ecl_syscall_e       (sys),
        .ecl_break_e         (brk),
        .ecl_ale_e           (ale),
        .ecl_ldst_addr_e     (ldst),
        .ecl_ertn_e          (ertn_e),
        .csr_ecl_crmd_ie     (ie),
        .csr_ecl_timer_intr  (timer),
        .ext_intr            (ext),
        .csr_eentry          (eentry),
        .csr_era             (era),
        .exu_ifu_except      (except_o),
        .ecl_csr_exccode_e   (code_o),
        .ecl_csr_badv_e      (badv_o),
        .ecl_csr_ertn_e      (ertn_o),
        .exu_ifu_redirect    (redir_o),
        .exu_ifu_redirect_pc (rpc_o),
        .ecl_kill_e          (kill_o),
        .ext_intr_sync       (sync_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exc, input logic [5:0] code,
                           input logic [31:0] badv, input logic ertn, input logic redir,
                           input logic [31:0] rpc, input logic kill);
        chk({tag, ".except"}, {31'h0, except_o}, {31'h0, exc});
        chk({tag, ".code"}, {26'h0, code_o}, {26'h0, code});
        chk({tag, ".badv"}, badv_o, badv);
        chk({tag, ".ertn"}, {31'h0, ertn_o}, {31'h0, ertn});
        chk({tag, ".redir"}, {31'h0, redir_o}, {31'h0, redir});
        chk({tag, ".rpc"}, rpc_o, rpc);
        chk({tag, ".kill"}, {31'h0, kill_o}, {31'h0, kill});
    endtask

    task automatic clear_faults();
        adef = 0; ill = 0; sys = 0; brk = 0; ale = 0; ertn_e = 0;
    endtask

    // Inputs change on the falling edge; outputs are checked 1ns later, well before posedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drain();
        valid_e = 0; clear_faults();
        repeat (3) cyc();
    endtask

    initial begin
        reset = 1; valid_e = 1; stall_e = 0; clear_faults(); ale = 1;
        ie = 0; timer = 0; ext = 0;
        pc_e = 32'h1c000100; ldst = 32'h1002; eentry = 32'h1c008000; era = 32'h1c000200;
        cyc(); cyc(); #1;
        chk_all("reset", 0, 6'h00, 0, 0, 0, 0, 0);
        chk("reset.sync", {31'h0, sync_o}, 0);

        // ALE with its kill window
        cyc(); reset = 0; #1;
        chk_all("ale", 1, 6'h09, 32'h1002, 0, 1, 32'h1c008000, 1);
        cyc(); clear_faults(); #1;
        chk_all("ale.k1", 0, 6'h00, 0, 0, 0, 0, 1);
        cyc(); #1;
        chk_all("ale.k2", 0, 6'h00, 0, 0, 0, 0, 1);
        cyc(); #1;
        chk_all("ale.idle", 0, 6'h00, 0, 0, 0, 0, 0);

        // priority
        ill = 1; sys = 1; ale = 1; #1;
        chk_all("prio.ine", 1, 6'h0D, 0, 0, 1, 32'h1c008000, 1);
        drain();
        valid_e = 1; ill = 1; sys = 1; ale = 1; ie = 1; timer = 1; #1;
        chk_all("prio.int", 1, 6'h00, 0, 0, 1, 32'h1c008000, 1);
        drain(); ie = 0; timer = 0;
        valid_e = 1; adef = 1; ale = 1; #1;
        chk_all("prio.adef", 1, 6'h08, 32'h1c000100, 0, 1, 32'h1c008000, 1);
        drain();
        valid_e = 1; brk = 1; sys = 1; #1;
        chk_all("prio.sys", 1, 6'h0B, 0, 0, 1, 32'h1c008000, 1);
        drain();
        valid_e = 1; brk = 1; ale = 1; #1;
        chk_all("prio.brk", 1, 6'h0C, 0, 0, 1, 32'h1c008000, 1);
        drain();

        // ertn
        valid_e = 1; ertn_e = 1; #1;
        chk_all("ertn", 0, 6'h00, 0, 1, 1, 32'h1c000200, 0);
        drain();
        valid_e = 1; ertn_e = 1; ill = 1; #1;
        chk_all("ertn.ine", 1, 6'h0D, 0, 0, 1, 32'h1c008000, 1);
        drain();

        // external interrupt: two sync flops before it is seen
        valid_e = 1; ie = 1; ext = 1; #1;
        chk_all("int.n0", 0, 6'h00, 0, 0, 0, 0, 0);
        cyc(); #1;
        chk_all("int.n1", 0, 6'h00, 0, 0, 0, 0, 0);
        chk("int.n1.sync", {31'h0, sync_o}, 0);
        cyc(); #1;
        chk_all("int.n2", 1, 6'h00, 0, 0, 1, 32'h1c008000, 1);
        chk("int.n2.sync", {31'h0, sync_o}, 1);
        drain();
        ie = 0; valid_e = 1; #1;
        chk_all("int.ie0", 0, 6'h00, 0, 0, 0, 0, 0);
        cyc(); #1;
        chk_all("int.ie0b", 0, 6'h00, 0, 0, 0, 0, 0);
        ie = 1; stall_e = 1; #1;
        chk_all("int.stall", 0, 6'h00, 0, 0, 0, 0, 0);
        cyc(); stall_e = 0; #1;
        chk_all("int.unstall", 1, 6'h00, 0, 0, 1, 32'h1c008000, 1);
        ext = 0; ie = 0;
        drain();
        valid_e = 0; ie = 1; #1;
        chk_all("int.bubble", 0, 6'h00, 0, 0, 0, 0, 0);
        ie = 0;
        drain();

        // kill window: faults during KILL are squashed
        valid_e = 1; ill = 1; #1;
        chk_all("kw.first", 1, 6'h0D, 0, 0, 1, 32'h1c008000, 1);
        cyc(); sys = 1; ill = 0; #1;
        chk_all("kw.plus1", 0, 6'h00, 0, 0, 0, 0, 1);
        cyc(); #1;
        chk_all("kw.plus2", 0, 6'h00, 0, 0, 0, 0, 1);
        cyc(); #1;
        chk_all("kw.plus3", 1, 6'h0B, 0, 0, 1, 32'h1c008000, 1);
        cyc(); reset = 1; #1;
        chk_all("kw.rst", 0, 6'h00, 0, 0, 0, 0, 0);
        cyc(); reset = 0; clear_faults(); #1;
        chk_all("kw.after", 0, 6'h00, 0, 0, 0, 0, 0);
        ale = 1; #1;
        chk_all("kw.idle", 1, 6'h09, 32'h1002, 0, 1, 32'h1c008000, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
